// File: rtl/unsigned_div_seq.sv
// Iterative restoring divider for unsigned WIDTH-bit operands, one quotient bit per clock,
// behind a start/busy/done handshake. Results are registered and held until the next done.
module unsigned_div_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] rem_r, rem_next;
  logic [WIDTH-1:0] quo_r, quo_next;
  logic [WIDTH-1:0] den_r, den_next;

  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] quotient_next;
  logic [WIDTH-1:0] remainder_next;
  logic             dbz_next;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  // Partial remainder shifted left by one, pulling in the next dividend bit from quo_r.
  // The remainder stays below the divisor, so WIDTH+1 bits hold the shifted value and the
  // borrow of the trial subtraction is exactly bit WIDTH.
  always_comb begin
    rem_shift = {rem_r, quo_r[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, den_r};
    rem_ge    = ~rem_diff[WIDTH];
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rem_next       = rem_r;
    quo_next       = quo_r;
    den_next       = den_r;
    busy_next      = busy;
    done_next      = 1'b0;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          quo_next   = dividend;
          den_next   = divisor;
          rem_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = (divisor == '0) ? S_ZERO : S_CALC;
        end
      end

      S_CALC: begin
        rem_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next = {quo_r[WIDTH-2:0], rem_ge};
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_next     = S_IDLE;
          cnt_next       = '0;
          busy_next      = 1'b0;
          done_next      = 1'b1;
          quotient_next  = quo_next;
          remainder_next = rem_next;
          dbz_next       = 1'b0;
        end
      end

      S_ZERO: begin
        // quo_r still holds the latched dividend here.
        state_next     = S_IDLE;
        busy_next      = 1'b0;
        done_next      = 1'b1;
        quotient_next  = '1;
        remainder_next = quo_r;
        dbz_next       = 1'b1;
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      den_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rem_r       <= rem_next;
      quo_r       <= quo_next;
      den_r       <= den_next;
      busy        <= busy_next;
      done        <= done_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
    end
  end

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Directed bench for unsigned_div_seq: latency, handshake, boundaries, reset abort and a
// back-to-back run checked against q*divisor + r == dividend.
module tb_unsigned_div_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_B2B = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unsigned_div_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (0 on timeout); busy must stay high before each edge.
  task automatic wait_done(input int limit, output int lat, output bit busy_ok);
    bit found;
    lat     = 0;
    busy_ok = 1'b1;
    found   = 1'b0;
    for (int k = 1; k <= limit && !found; k++) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat   = k;
        found = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%0d r=%0d, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_divide();
    logic [WIDTH-1:0] tab[6][4] = '{
      '{8'd200, 8'd7,   8'd28,  8'd4},
      '{8'd255, 8'd1,   8'd255, 8'd0},
      '{8'd3,   8'd10,  8'd0,   8'd3},
      '{8'd0,   8'd9,   8'd0,   8'd0},
      '{8'd255, 8'd255, 8'd1,   8'd0},
      '{8'd1,   8'd255, 8'd0,   8'd1}
    };
    int lat;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      launch(tab[i][0], tab[i][1]);
      wait_done(20, lat, bok);
      n_checks++;
      if (lat != 8 || !bok) begin
        n_fail++;
        $display("FAIL div_latency[%0d]: latency=%0d busy_held=%b, required 8 1", i, lat, bok);
      end
      n_checks++;
      if (quotient !== tab[i][2] || remainder !== tab[i][3] || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL div_result[%0d] %0d/%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0",
                 i, tab[i][0], tab[i][1], quotient, remainder, div_by_zero, tab[i][2], tab[i][3]);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL div_busy_at_done[%0d]: busy=%b, required 0", i, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || quotient !== tab[i][2] || remainder !== tab[i][3]) begin
        n_fail++;
        $display("FAIL div_pulse_hold[%0d]: done=%b q=%0d r=%0d, required 0 %0d %0d",
                 i, done, quotient, remainder, tab[i][2], tab[i][3]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bit bok;
    launch(8'd5, 8'd0);
    wait_done(20, lat, bok);
    n_checks++;
    if (lat != 1 || !bok || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_latency: latency=%0d busy_held=%b busy=%b, required 1 1 0", lat, bok, busy);
    end
    n_checks++;
    if (quotient !== 8'd255 || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: q=%0d r=%0d dbz=%b, required 255 5 1", quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_hold: done=%b dbz=%b, required 0 1", done, div_by_zero);
    end
    // Next operation must not disturb the held results until its own done.
    launch(8'd20, 8'd6);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (div_by_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_midflight: dbz=%b q=%0d r=%0d busy=%b, required 1 255 5 1",
               div_by_zero, quotient, remainder, busy);
    end
    wait_done(20, lat, bok);
    n_checks++;
    if (lat + 3 != 8 || div_by_zero !== 1'b0 || quotient !== 8'd3 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL dbz_clear: latency=%0d dbz=%b q=%0d r=%0d, required 8 0 3 2",
               lat + 3, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit bok;
    launch(8'd100, 8'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    wait_done(20, lat, bok);
    dividend = 8'd77;
    divisor  = 8'd0;
    n_checks++;
    if (lat + 4 != 8 || !bok) begin
      n_fail++;
      $display("FAIL busy_start_latency: latency=%0d busy_held=%b, required 8 1", lat + 4, bok);
    end
    n_checks++;
    if (quotient !== 8'd33 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_result: q=%0d r=%0d dbz=%b, required 33 1 0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit bok;
    bit seen;
    launch(8'd100, 8'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b dbz=%b q=%0d r=%0d, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_done: done/busy seen=%b, required 0", seen);
    end
    launch(8'd17, 8'd4);
    wait_done(20, lat, bok);
    n_checks++;
    if (lat != 8 || quotient !== 8'd4 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover: latency=%0d q=%0d r=%0d dbz=%b, required 8 4 1 0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] recon;
    int lat;
    bit bok;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom_range(1, 255));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    for (int i = 0; i < N_B2B; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
      wait_done(20, lat, bok);
      n_checks++;
      if (lat != ((b == '0) ? 1 : 8) || !bok) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL b2b_latency[%0d] %0d/%0d: latency=%0d busy_held=%b", i, a, b, lat, bok);
      end
      if (b == '0) begin
        n_checks++;
        if (quotient !== '1 || remainder !== a || div_by_zero !== 1'b1) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL b2b_dbz[%0d] %0d/0: q=%0d r=%0d dbz=%b, required 255 %0d 1",
                     i, a, quotient, remainder, div_by_zero, a);
        end
      end else begin
        recon = (2*WIDTH)'(quotient) * (2*WIDTH)'(b) + (2*WIDTH)'(remainder);
        n_checks++;
        if (recon !== (2*WIDTH)'(a) || remainder >= b || div_by_zero !== 1'b0) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL b2b_identity[%0d] %0d/%0d: q=%0d r=%0d dbz=%b q*d+r=%0d",
                     i, a, b, quotient, remainder, div_by_zero, recon);
        end
        n_checks++;
        if (quotient !== a / b || remainder !== a % b) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL b2b_model[%0d] %0d/%0d: q=%0d r=%0d, required %0d %0d",
                     i, a, b, quotient, remainder, a / b, a % b);
        end
      end
      if (i < N_B2B - 1) begin
        a = WIDTH'($urandom);
        b = ($urandom_range(0, 31) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
        dividend = a;
        divisor  = b;
        start    = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divide();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
